spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 18 +
 rtl/spi_pin_sync.sv | 41 ++++
 rtl/spi_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_slave.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared constants for the SPI mode-0 slave: FSM state
//               encodings and default frame / synchronizer sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    localparam int c_data_width_def  = 8;
    localparam int c_sync_stages_def = 2;

    localparam int                   c_state_w   = 1;
    localparam logic [c_state_w-1:0] c_st_idle   = 1'b0;
    localparam logic [c_state_w-1:0] c_st_active = 1'b1;

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_pin_sync
// Description : Multi-flop synchronizer for one asynchronous pin, with
//               rise/fall pulses derived from the last two synchronized
//               samples.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the pin through the synchronizer chain and keep one older sample
    // for edge detection; everything clears to 0 so a low pin held through
    // reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI mode-0 (CPOL=0, CPHA=0) MSB-first slave, oversampled by
//               the system clock. Single transmit holding register and a
//               single receive data register with valid/ready handshakes,
//               sticky overrun / underrun flags and a per-byte irq pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = c_sync_stages_def,
    parameter int DATA_WIDTH  = c_data_width_def
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  irq,
    output logic                  overrun,
    output logic                  tx_underrun,
    input  logic                  clr_flags
);

    localparam int                 c_cnt_w = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_cs_sync,   w_cs_rise,   w_cs_fall;
    logic w_unused;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (sclk),
        .o_sync (w_sclk_sync),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (cs),
        .o_sync (w_cs_sync),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    // The sclk level and the cs rise pulse have no consumer; cs high is
    // acted on as a level so a deselect is never missed.
    assign w_unused = w_sclk_sync ^ w_cs_rise;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi_s;

    // mosi only needs the same delay as sclk so data and edge stay aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_state_w-1:0]  r_state;
    logic [c_cnt_w-1:0]    r_bit_cnt;
    logic                  r_byte_done;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_tx_hold;
    logic                  r_tx_full;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_irq;
    logic                  r_overrun;
    logic                  r_tx_underrun;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic                  w_active;
    logic                  w_frame_start;
    logic                  w_in_frame;
    logic                  w_rise_act;
    logic                  w_fall_act;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_byte_end;
    logic                  w_rx_take;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_rx_byte;

    assign w_active      = (r_state == c_st_active);
    assign w_frame_start = ~w_active & w_cs_fall;
    assign w_in_frame    = w_active & ~w_cs_sync;
    assign w_rise_act    = w_in_frame & w_sclk_rise;
    assign w_fall_act    = w_in_frame & w_sclk_fall;
    // The first falling edge after a completed byte reloads instead of shifting
    assign w_load        = w_frame_start | (w_fall_act & r_byte_done);
    assign w_shift       = w_fall_act & ~r_byte_done;
    assign w_byte_end    = w_rise_act & (r_bit_cnt == c_last);
    assign w_rx_take     = w_byte_end & ~r_rx_valid;
    assign w_accept      = tx_valid & ~r_tx_full;
    assign w_rx_byte     = {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};

    // Frame FSM, bit counter and "byte just completed" marker
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_cs_fall) begin
                        r_state     <= c_st_active;
                        r_bit_cnt   <= '0;
                        r_byte_done <= 1'b0;
                    end
                end
                c_st_active: begin
                    if (w_cs_sync) begin
                        r_state     <= c_st_idle;
                        r_bit_cnt   <= '0;
                        r_byte_done <= 1'b0;
                    end else if (w_sclk_rise) begin
                        if (r_bit_cnt == c_last) begin
                            r_bit_cnt   <= '0;
                            r_byte_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        r_byte_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Transmit holding register and shift register; an accept in the same
    // cycle as a load refills the holding register after the load takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_shift <= '0;
            r_tx_hold  <= '0;
            r_tx_full  <= 1'b0;
        end else begin
            if (w_load) begin
                r_tx_shift <= r_tx_full ? r_tx_hold : '0;
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (w_accept) begin
                r_tx_hold <= tx_data;
                r_tx_full <= 1'b1;
            end else if (w_load) begin
                r_tx_full <= 1'b0;
            end
        end
    end

    // Receive shift register, data register handshake and irq pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= w_rx_take;
            if (w_rise_act) begin
                r_rx_shift <= w_rx_byte;
            end
            if (w_rx_take) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid & rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    // Sticky error flags; a set in the same cycle as clr_flags wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun     <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_overrun     <= (r_overrun     & ~clr_flags) | (w_byte_end & r_rx_valid);
            r_tx_underrun <= (r_tx_underrun & ~clr_flags) | (w_load & ~r_tx_full);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = w_active;
    assign miso_oe     = w_active;
    assign miso        = w_active & r_tx_shift[DATA_WIDTH-1];
    assign tx_ready    = ~r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign irq         = r_irq;
    assign overrun     = r_overrun;
    assign tx_underrun = r_tx_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Self-checking bench for spi_slave. A transaction-level model
//               of the holding register, receive register and flags predicts
//               every miso bit and the register state after each byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int SYNC = 2;
    localparam int DW   = 8;
    localparam int HALF = 5;   // clk cycles per sclk half period

    logic          clk = 1'b0;
    logic          reset, sclk, cs, mosi, miso, miso_oe;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_valid, tx_ready, rx_valid, rx_ready;
    logic          busy, irq, overrun, tx_underrun, clr_flags;

    spi_slave #(.SYNC_STAGES(SYNC), .DATA_WIDTH(DW)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .irq         (irq),
        .overrun     (overrun),
        .tx_underrun (tx_underrun),
        .clr_flags   (clr_flags)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int irq_cnt = 0;

    // Behavioural model state
    logic       m_tx_full  = 1'b0;
    logic [7:0] m_tx_hold  = 8'h00;
    logic       m_rx_valid = 1'b0;
    logic [7:0] m_rx_data  = 8'h00;
    logic       m_overrun  = 1'b0;
    logic       m_underrun = 1'b0;
    int         m_irq      = 0;

    // Per-frame plan and captured results
    logic [7:0] f_mo   [4];
    logic [7:0] f_tx   [4];
    logic [7:0] f_miso [4];
    logic [7:0] f_rx   [4];
    bit         f_dotx [4];
    bit         f_cons [4];
    bit         f_clr  [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a shift-register load consumes the holding register or underruns
    function automatic logic [7:0] model_load();
        if (m_tx_full) begin
            m_tx_full = 1'b0;
            return m_tx_hold;
        end
        m_underrun = 1'b1;
        return 8'h00;
    endfunction

    // Model: a completed byte is accepted or dropped with overrun
    task automatic model_rx(input logic [7:0] b);
        if (!m_rx_valid) begin
            m_rx_valid = 1'b1;
            m_rx_data  = b;
            m_irq++;
        end else begin
            m_overrun = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_tx_full  = 1'b0;
        m_tx_hold  = 8'h00;
        m_rx_valid = 1'b0;
        m_rx_data  = 8'h00;
        m_overrun  = 1'b0;
        m_underrun = 1'b0;
    endtask

    task automatic plan_clear();
        for (int b = 0; b < 4; b++) begin
            f_mo[b] = 8'h00; f_tx[b] = 8'h00; f_miso[b] = 8'h00; f_rx[b] = 8'h00;
            f_dotx[b] = 1'b0; f_cons[b] = 1'b0; f_clr[b] = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_rx_valid"}, rx_valid, m_rx_valid);
        check({tag, "_rx_data"}, rx_data, m_rx_data);
        check({tag, "_overrun"}, overrun, m_overrun);
        check({tag, "_underrun"}, tx_underrun, m_underrun);
        check({tag, "_tx_ready"}, tx_ready, !m_tx_full);
        check({tag, "_irq_count"}, irq_cnt, m_irq);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_miso"}, miso, 0);
        check({tag, "_miso_oe"}, miso_oe, 0);
        check({tag, "_tx_ready"}, tx_ready, 1);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_irq"}, irq, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_underrun"}, tx_underrun, 0);
    endtask

    // One cycle: offer a byte if the model says there is room
    task automatic tx_write(input logic [7:0] b);
        check("tx_ready_pre", tx_ready, !m_tx_full);
        if (!m_tx_full) begin
            tx_data  = b;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            m_tx_full = 1'b1;
            m_tx_hold = b;
        end else begin
            tick(1);
        end
    endtask

    // One cycle: consume the receive register if the model says it is valid
    task automatic rx_consume();
        check("rx_valid_pre", rx_valid, m_rx_valid);
        if (m_rx_valid) begin
            check("rx_data_pre", rx_data, m_rx_data);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            m_rx_valid = 1'b0;
        end else begin
            tick(1);
        end
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        m_overrun  = 1'b0;
        m_underrun = 1'b0;
    endtask

    // Master side of one cs assertion; abort_bits>0 truncates the last byte
    task automatic run_frame(input int nbytes, input int abort_bits);
        logic [7:0] exp_tx;
        int         nb;
        int         k;
        cs = 1'b0;
        exp_tx = model_load();
        tick(8);
        for (int b = 0; b < nbytes; b++) begin
            nb = (b == nbytes - 1 && abort_bits > 0) ? abort_bits : DW;
            for (int i = 0; i < nb; i++) begin
                sclk = 1'b0;
                if (b > 0 && i == 0) exp_tx = model_load();
                mosi = f_mo[b][7-i];
                tick(HALF);
                f_miso[b][7-i] = miso;
                check("miso_bit", miso, exp_tx[7-i]);
                sclk = 1'b1;
                if (i == 3) begin
                    if (f_dotx[b]) tx_write(f_tx[b]); else tick(1);
                    if (f_cons[b]) rx_consume();      else tick(1);
                    if (f_clr[b])  clear_flags();     else tick(1);
                    tick(HALF - 3);
                end else begin
                    tick(HALF);
                end
            end
            if (nb == DW) begin
                model_rx(f_mo[b]);
                f_rx[b] = rx_data;
                check_state("byte");
            end
        end
        sclk = 1'b0;
        if (abort_bits == 0) exp_tx = model_load();
        tick(HALF);
        cs = 1'b1;
        k = 0;
        while (busy && k < SYNC + 2) begin
            tick(1);
            k++;
        end
        check("busy_drop", busy, 0);
        tick(4);
        check_state("frame_end");
    endtask

    // Per-cycle monitor: irq counting and always-true output relations
    always @(negedge clk) begin
        if (irq) irq_cnt = irq_cnt + 1;
        check("oe_eq_busy", miso_oe, busy);
        if (!busy) check("miso_idle_low", miso, 0);
        if (irq) check("irq_with_valid", rx_valid, 1);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int nbr;
        int abr;
        reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clr_flags = 1'b0;
        plan_clear();
        tick(4);
        check_reset("por");
        reset = 1'b0;
        tick(6);
        check_state("idle");

        // Preloaded A5 out while 3C comes in
        tx_write(8'hA5);
        plan_clear(); f_mo[0] = 8'h3C;
        base = irq_cnt;
        run_frame(1, 0);
        check("t1_miso", f_miso[0], 8'hA5);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_rx_valid", rx_valid, 1);
        check("t1_irq", irq_cnt - base, 1);
        rx_consume(); clear_flags(); tick(2);
        check_state("t1_end");

        // Two bytes, second tx byte written during the first byte
        tx_write(8'h11);
        plan_clear(); f_mo[0] = 8'hDE; f_mo[1] = 8'hAD;
        f_dotx[0] = 1'b1; f_tx[0] = 8'h22; f_cons[1] = 1'b1;
        base = irq_cnt;
        run_frame(2, 0);
        check("t2_miso0", f_miso[0], 8'h11);
        check("t2_miso1", f_miso[1], 8'h22);
        check("t2_rx0", f_rx[0], 8'hDE);
        check("t2_rx1", rx_data, 8'hAD);
        check("t2_irq", irq_cnt - base, 2);

        // No preload: zeros out, underrun, then clear
        rx_consume(); clear_flags();
        plan_clear(); f_mo[0] = 8'h5A;
        run_frame(1, 0);
        check("t3_miso", f_miso[0], 8'h00);
        check("t3_underrun", tx_underrun, 1);
        check("t3_rx_data", rx_data, 8'h5A);
        clear_flags();
        check("t3_underrun_clr", tx_underrun, 0);

        // Receiver not ready: second byte dropped with overrun
        rx_consume(); clear_flags();
        plan_clear(); f_mo[0] = 8'h55; f_mo[1] = 8'hAA;
        base = irq_cnt;
        run_frame(2, 0);
        check("t4_rx_data", rx_data, 8'h55);
        check("t4_overrun", overrun, 1);
        check("t4_irq", irq_cnt - base, 1);

        // Abort after four bits, then a clean frame
        rx_consume(); clear_flags();
        plan_clear(); f_mo[0] = 8'hF0;
        base = irq_cnt;
        run_frame(1, 4);
        check("t5_rx_valid", rx_valid, 0);
        check("t5_irq", irq_cnt - base, 0);
        plan_clear(); f_mo[0] = 8'h81;
        run_frame(1, 0);
        check("t5_rx_data", rx_data, 8'h81);
        check("t5_rx_valid2", rx_valid, 1);

        // Reset in the middle of a selected frame
        rx_consume(); clear_flags();
        tx_write(8'h77);
        cs = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b0; mosi = 1'b1; tick(HALF);
            sclk = 1'b1; tick(HALF);
        end
        sclk = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_reset();
        check_reset("mid");
        base = irq_cnt;
        for (int i = 0; i < 12; i++) begin
            sclk = 1'b0; mosi = i[0]; tick(HALF);
            sclk = 1'b1; tick(HALF);
        end
        sclk = 1'b0;
        tick(HALF);
        check("t6_busy", busy, 0);
        check("t6_rx_valid", rx_valid, 0);
        check("t6_irq", irq_cnt - base, 0);
        cs = 1'b1;
        tick(8);
        plan_clear(); f_mo[0] = 8'h3C;
        run_frame(1, 0);
        check("t6_rx_data", rx_data, 8'h3C);
        check("t6_miso", f_miso[0], 8'h00);
        check("t6_underrun", tx_underrun, 1);

        // Randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            plan_clear();
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom)); else tick(1);
            if ($urandom_range(0, 2) == 0) rx_consume();
            if ($urandom_range(0, 3) == 0) clear_flags();
            nbr = $urandom_range(1, 3);
            abr = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
            for (int b = 0; b < 4; b++) begin
                f_mo[b]   = 8'($urandom);
                f_tx[b]   = 8'($urandom);
                f_dotx[b] = ($urandom_range(0, 1) == 1);
                f_cons[b] = ($urandom_range(0, 1) == 1);
                f_clr[b]  = ($urandom_range(0, 3) == 0);
            end
            run_frame(nbr, abr);
            tick($urandom_range(1, 5));
        end
        check_state("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
